// File: rtl/tbuf_bus_arbiter.sv
// Round-robin arbiter driving the EN pins of N tristate buffers on one shared bus.
// Define TBUF_ARB_BURST_LIMIT_EN to cap each ownership at MAX_BURST granted cycles.
module tbuf_bus_arbiter #(
  parameter int N         = 4,
  parameter int MAX_BURST = 8,
  parameter int TURN_CYC  = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N-1:0]         REQ,
  output logic [N-1:0]         GNT,
  output logic [$clog2(N)-1:0] OWNER,
  output logic                 BUSY,
  output logic                 TURN
);

  localparam int OW = $clog2(N);
  localparam int TW = 4;

  if (N < 2 || N > 16 || MAX_BURST < 2 || MAX_BURST > 255 ||
      TURN_CYC < 1 || TURN_CYC > 15) begin : g_param_range
    $error("tbuf_bus_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, GRANT, TURNAROUND} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            busy_q, turn_q;
  logic [OW:0]     pick;
  logic            grant_exit;

  // Nearest set request after `last`, wrapping; the final overwrite is the closest one.
  function automatic logic [OW:0] rr_pick(input logic [N-1:0] req, input logic [OW-1:0] last);
    logic [OW:0] r;
    int          j;
    r = '0;
    for (int i = N; i >= 1; i--) begin
      j = (int'(last) + i) % N;
      if (req[OW'(j)]) r = {1'b1, OW'(j)};
    end
    return r;
  endfunction

`ifdef TBUF_ARB_BURST_LIMIT_EN
  localparam int BW = $clog2(MAX_BURST);
  logic [BW-1:0] cnt_q, cnt_d;
  logic          burst_done;
  assign burst_done = (cnt_q == BW'(MAX_BURST - 1));
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    tcnt_d     = tcnt_q;
    pick       = rr_pick(REQ, owner_q);
    grant_exit = !REQ[owner_q];
`ifdef TBUF_ARB_BURST_LIMIT_EN
    cnt_d      = cnt_q;
    grant_exit = grant_exit || burst_done;
`endif
    case (state_q)
      IDLE: begin
        if (pick[OW]) begin
          state_d              = GRANT;
          owner_d              = pick[OW-1:0];
          gnt_d                = '0;
          gnt_d[pick[OW-1:0]]  = 1'b1;
`ifdef TBUF_ARB_BURST_LIMIT_EN
          cnt_d                = '0;
`endif
        end
      end
      GRANT: begin
        if (grant_exit) begin
          state_d = TURNAROUND;
          gnt_d   = '0;
          tcnt_d  = '0;
`ifdef TBUF_ARB_BURST_LIMIT_EN
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + BW'(1);
`endif
        end
      end
      TURNAROUND: begin
        // Length is fixed; REQ only matters at the final decision edge.
        if (tcnt_q == TW'(TURN_CYC - 1)) begin
          tcnt_d = '0;
          if (pick[OW]) begin
            state_d             = GRANT;
            owner_d             = pick[OW-1:0];
            gnt_d               = '0;
            gnt_d[pick[OW-1:0]] = 1'b1;
`ifdef TBUF_ARB_BURST_LIMIT_EN
            cnt_d               = '0;
`endif
          end else begin
            state_d = IDLE;
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= OW'(N - 1);
      tcnt_q  <= '0;
      busy_q  <= 1'b0;
      turn_q  <= 1'b0;
`ifdef TBUF_ARB_BURST_LIMIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      tcnt_q  <= tcnt_d;
      busy_q  <= |gnt_d;
      turn_q  <= (state_d == TURNAROUND);
`ifdef TBUF_ARB_BURST_LIMIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign GNT   = gnt_q;
  assign OWNER = owner_q;
  assign BUSY  = busy_q;
  assign TURN  = turn_q;

endmodule
